// File: rtl/hazard_unit_mc_if.sv
// Hazard-unit bundle: pipeline register addresses and enables in, stage
// controls, forward selects and perf counters out.
interface hazard_unit_mc_if #(
  parameter int AW = 5,
  parameter int CW = 16
);
  logic [AW-1:0] i_rs1_addr_decode;
  logic [AW-1:0] i_rs2_addr_decode;
  logic [AW-1:0] i_rs1_addr_execute;
  logic [AW-1:0] i_rs2_addr_execute;
  logic [AW-1:0] i_rd_addr_execute;
  logic [AW-1:0] i_rd_addr_memory;
  logic [AW-1:0] i_rd_addr_writeback;
  logic          i_rd_wren_memory;
  logic          i_rd_wren_writeback;
  logic          i_ld_execute;
  logic          i_ld_memory;
  logic          i_mdu_execute;
  logic          i_pc_sel;
  logic [1:0]    o_foward_a_execution;
  logic [1:0]    o_foward_b_execution;
  logic          o_stall_fetch;
  logic          o_stall_decode;
  logic          o_stall_execute;
  logic          o_stall_memory;
  logic          o_flush_decode;
  logic          o_flush_execute;
  logic          o_flush_memory;
  logic          o_flush_writeback;
  logic          o_mdu_done;
  logic [CW-1:0] o_stall_count;
  logic [CW-1:0] o_flush_count;

  modport master (
    output i_rs1_addr_decode, i_rs2_addr_decode, i_rs1_addr_execute,
           i_rs2_addr_execute, i_rd_addr_execute, i_rd_addr_memory,
           i_rd_addr_writeback, i_rd_wren_memory, i_rd_wren_writeback,
           i_ld_execute, i_ld_memory, i_mdu_execute, i_pc_sel,
    input  o_foward_a_execution, o_foward_b_execution, o_stall_fetch,
           o_stall_decode, o_stall_execute, o_stall_memory, o_flush_decode,
           o_flush_execute, o_flush_memory, o_flush_writeback, o_mdu_done,
           o_stall_count, o_flush_count
  );

  modport slave (
    input  i_rs1_addr_decode, i_rs2_addr_decode, i_rs1_addr_execute,
           i_rs2_addr_execute, i_rd_addr_execute, i_rd_addr_memory,
           i_rd_addr_writeback, i_rd_wren_memory, i_rd_wren_writeback,
           i_ld_execute, i_ld_memory, i_mdu_execute, i_pc_sel,
    output o_foward_a_execution, o_foward_b_execution, o_stall_fetch,
           o_stall_decode, o_stall_execute, o_stall_memory, o_flush_decode,
           o_flush_execute, o_flush_memory, o_flush_writeback, o_mdu_done,
           o_stall_count, o_flush_count
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding controller for a 5-stage pipeline with multi-cycle MDU
// ops in E and multi-cycle loads in M; stall/flush perf counters saturate.
module hazard_unit_mc #(
  parameter int AW      = 5,
  parameter int MDU_LAT = 4,
  parameter int LSU_LAT = 2,
  parameter int CW      = 16
) (
  input logic             i_clk,
  input logic             i_reset,
  hazard_unit_mc_if.slave hif
);
  localparam int            MW         = $clog2(MDU_LAT) + 1;
  localparam int            LW         = $clog2(LSU_LAT) + 1;
  localparam logic [MW-1:0] MDU_RELOAD = MW'(MDU_LAT - 1);
  localparam logic [LW-1:0] LSU_RELOAD = LW'(LSU_LAT - 1);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

  logic [MW-1:0] mdu_cnt_r, mdu_cnt_nx_s;
  logic [LW-1:0] lsu_cnt_r, lsu_cnt_nx_s;
  logic [CW-1:0] stall_cnt_r, flush_cnt_r;
  logic          mdu_stall_s, mdu_done_s, lsu_stall_s, load_use_s;
  logic [3:0]    stall_s, flush_s;   // {F,D,E,M} and {D,E,M,W}
  logic [1:0]    fwd_a_s, fwd_b_s;

  // M has priority over W; x0 and disabled writes never forward.
  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs,
                                         input logic [AW-1:0] rd_m, input logic wren_m,
                                         input logic [AW-1:0] rd_w, input logic wren_w);
    if (wren_m && (rd_m != {AW{1'b0}}) && (rd_m == rs))
      return 2'b01;
    else if (wren_w && (rd_w != {AW{1'b0}}) && (rd_w == rs))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  // MDU occupancy counter: next value, stall and done.
  always_comb begin
    mdu_stall_s  = 1'b0;
    mdu_done_s   = 1'b0;
    mdu_cnt_nx_s = {MW{1'b0}};
    if (MDU_LAT == 1) begin
      mdu_done_s = hif.i_mdu_execute;
    end else if (mdu_cnt_r == {MW{1'b0}}) begin
      if (hif.i_mdu_execute) begin
        mdu_cnt_nx_s = MDU_RELOAD;
        mdu_stall_s  = 1'b1;
      end else begin
        mdu_cnt_nx_s = {MW{1'b0}};
      end
    end else if (mdu_cnt_r == MW'(1'b1)) begin
      mdu_done_s = 1'b1;
    end else begin
      mdu_cnt_nx_s = mdu_cnt_r - MW'(1'b1);
      mdu_stall_s  = 1'b1;
    end
  end

  // LSU occupancy counter: same scheme driven by loads in M.
  always_comb begin
    lsu_stall_s  = 1'b0;
    lsu_cnt_nx_s = {LW{1'b0}};
    if (LSU_LAT == 1) begin
      lsu_stall_s = 1'b0;
    end else if (lsu_cnt_r == {LW{1'b0}}) begin
      if (hif.i_ld_memory) begin
        lsu_cnt_nx_s = LSU_RELOAD;
        lsu_stall_s  = 1'b1;
      end else begin
        lsu_cnt_nx_s = {LW{1'b0}};
      end
    end else if (lsu_cnt_r == LW'(1'b1)) begin
      lsu_cnt_nx_s = {LW{1'b0}};
    end else begin
      lsu_cnt_nx_s = lsu_cnt_r - LW'(1'b1);
      lsu_stall_s  = 1'b1;
    end
  end

  assign load_use_s = hif.i_ld_execute && (hif.i_rd_addr_execute != {AW{1'b0}}) &&
                      ((hif.i_rd_addr_execute == hif.i_rs1_addr_decode) ||
                       (hif.i_rd_addr_execute == hif.i_rs2_addr_decode));

  // Stall/flush composition; a branch is only honoured when E is free to move.
  always_comb begin
    stall_s = 4'b0000;
    flush_s = 4'b0000;
    fwd_a_s = fwd_sel(hif.i_rs1_addr_execute, hif.i_rd_addr_memory, hif.i_rd_wren_memory,
                      hif.i_rd_addr_writeback, hif.i_rd_wren_writeback);
    fwd_b_s = fwd_sel(hif.i_rs2_addr_execute, hif.i_rd_addr_memory, hif.i_rd_wren_memory,
                      hif.i_rd_addr_writeback, hif.i_rd_wren_writeback);
    if (lsu_stall_s) begin
      stall_s = 4'b1111;
      flush_s = 4'b0001;
    end else if (mdu_stall_s) begin
      stall_s = 4'b1110;
      flush_s = 4'b0010;
    end else if (hif.i_pc_sel) begin
      flush_s = 4'b1100;
    end else if (load_use_s) begin
      stall_s = 4'b1100;
      flush_s = 4'b0100;
    end else begin
      stall_s = 4'b0000;
      flush_s = 4'b0000;
    end
  end

  // Drive outputs, all forced low while reset is held.
  always_comb begin
    hif.o_foward_a_execution = 2'b00;
    hif.o_foward_b_execution = 2'b00;
    {hif.o_stall_fetch, hif.o_stall_decode, hif.o_stall_execute, hif.o_stall_memory} = 4'b0000;
    {hif.o_flush_decode, hif.o_flush_execute, hif.o_flush_memory, hif.o_flush_writeback} = 4'b0000;
    hif.o_mdu_done    = 1'b0;
    hif.o_stall_count = {CW{1'b0}};
    hif.o_flush_count = {CW{1'b0}};
    if (!i_reset) begin
      hif.o_foward_a_execution = fwd_a_s;
      hif.o_foward_b_execution = fwd_b_s;
      {hif.o_stall_fetch, hif.o_stall_decode, hif.o_stall_execute, hif.o_stall_memory} = stall_s;
      {hif.o_flush_decode, hif.o_flush_execute, hif.o_flush_memory, hif.o_flush_writeback} = flush_s;
      hif.o_mdu_done    = mdu_done_s;
      hif.o_stall_count = stall_cnt_r;
      hif.o_flush_count = flush_cnt_r;
    end else begin
      hif.o_mdu_done = 1'b0;
    end
  end

  // Occupancy counters and saturating perf counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mdu_cnt_r   <= {MW{1'b0}};
      lsu_cnt_r   <= {LW{1'b0}};
      stall_cnt_r <= {CW{1'b0}};
      flush_cnt_r <= {CW{1'b0}};
    end else begin
      mdu_cnt_r <= mdu_cnt_nx_s;
      lsu_cnt_r <= lsu_cnt_nx_s;
      if (stall_s[3] && (stall_cnt_r != CNT_MAX))
        stall_cnt_r <= stall_cnt_r + CW'(1'b1);
      if (flush_s[3] && (flush_cnt_r != CNT_MAX))
        flush_cnt_r <= flush_cnt_r + CW'(1'b1);
    end
  end
endmodule
